// File: rtl/scalar_alu_pipe.sv
// Scalar ALU with a single-entry result register and a multi-cycle multiplier.
// Accepts one operation per cycle when the result slot is free or being drained.
// Non-multiply results appear one cycle after accept. Multiplies hold the pipe
// for MUL_LAT cycles.
//
// state | meaning
// IDLE  | no result held, ready for an operation
// MUL   | multiply in progress, counter running toward zero
// HOLD  | result held until the consumer takes it
module scalar_alu_pipe #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         control,
  input  logic                b64_op,
  input  logic [2*DATA_W-1:0] s1,
  input  logic [2*DATA_W-1:0] s2,
  input  logic [2*DATA_W-1:0] exec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out,
  output logic                scc_val,
  output logic                scc_wr,
  output logic                illegal
);

  localparam int XW   = 2 * DATA_W;
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [7:0] FMT_SOPP = 8'h01;
  localparam logic [7:0] FMT_SOP1 = 8'h02;
  localparam logic [7:0] FMT_SOPC = 8'h04;
  localparam logic [7:0] FMT_SOP2 = 8'h08;
  localparam logic [7:0] FMT_SOPK = 8'h10;

  // A latency of 1 means the multiply completes like any other op, with no MUL state.
  localparam logic       MUL_MULTI = (MUL_LAT > 1);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [XW-1:0]     out_q, out_d;
  logic              scc_val_q, scc_val_d;
  logic              scc_wr_q, scc_wr_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic              mul_k_q, mul_k_d;

  logic accept, load_res, load_mul, load_prod;

  // ------------------------------------------------------------------
  // Operand views and shared arithmetic
  // ------------------------------------------------------------------
  logic [7:0]        fmt;
  logic [23:0]       opc;
  logic [DATA_W-1:0] a, b;
  logic [DATA_W:0]   add_c;
  logic [DATA_W-1:0] sum, diff, simm16, pc_rel, ashr_res;
  logic [SH_W-1:0]   shamt;
  logic              add_ovf, sub_ovf, lt_u, gt_u, lt_s, eq;
  logic [XW-1:0]     wmask;

  assign fmt     = control[31:24];
  assign opc     = control[23:0];
  assign a       = s1[DATA_W-1:0];
  assign b       = s2[DATA_W-1:0];
  assign add_c   = {1'b0, a} + {1'b0, b};
  assign sum     = add_c[DATA_W-1:0];
  assign diff    = a - b;
  assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
  assign lt_u    = a < b;
  assign gt_u    = b < a;
  assign lt_s    = $signed(a) < $signed(b);
  assign eq      = a == b;
  assign simm16  = {{(DATA_W-16){s2[15]}}, s2[15:0]};
  assign pc_rel  = a + {simm16[DATA_W-3:0], 2'b00} + {{(DATA_W-3){1'b0}}, 3'b100};
  assign shamt   = b[SH_W-1:0];
  assign ashr_res = $signed(a) >>> shamt;
  // 32-bit ops keep only the low half so the upper half of out is always zero.
  assign wmask   = b64_op ? {XW{1'b1}} : {{DATA_W{1'b0}}, {DATA_W{1'b1}}};

  // Single multiplier: fed from the captured operands while a multiply is running,
  // otherwise straight from the inputs (used when MUL_LAT is 1).
  logic [DATA_W-1:0] mul_a, mul_b;
  logic [XW-1:0]     mul_a_x, mul_b_x, prod;
  logic              prod_ovf;

  assign mul_a    = (state_q == ST_MUL) ? mul_a_q : a;
  assign mul_b    = (state_q == ST_MUL) ? mul_b_q : b;
  assign mul_a_x  = {{DATA_W{mul_a[DATA_W-1]}}, mul_a};
  assign mul_b_x  = {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
  assign prod     = mul_a_x * mul_b_x;
  assign prod_ovf = prod[XW-1:DATA_W] != {DATA_W{prod[DATA_W-1]}};

  // ------------------------------------------------------------------
  // Operation decode
  // ------------------------------------------------------------------
  logic [XW-1:0] res_out, res_out_m;
  logic          res_scc, res_nz, res_wr, res_ill, res_mul, res_mulk, res_scc_f;

  // Decode format/opcode into a result, its SCC effect and the multiply flags.
  always_comb begin
    res_out  = '0;
    res_scc  = 1'b0;
    res_nz   = 1'b0;
    res_wr   = 1'b0;
    res_ill  = 1'b0;
    res_mul  = 1'b0;
    res_mulk = 1'b0;
    case (fmt)
      FMT_SOPP: begin
        case (opc)
          24'h02, 24'h04, 24'h05, 24'h06, 24'h08: res_out = {{DATA_W{1'b0}}, pc_rel};
          default: res_ill = 1'b1;
        endcase
      end
      FMT_SOP1: begin
        case (opc)
          24'h03, 24'h04: res_out = s1;
          24'h07, 24'h08: begin res_out = ~s1;       res_nz = 1'b1; res_wr = 1'b1; end
          24'h24:         begin res_out = s1 & exec; res_nz = 1'b1; res_wr = 1'b1; end
          default: res_ill = 1'b1;
        endcase
      end
      FMT_SOP2: begin
        case (opc)
          24'h00: begin res_out = {{DATA_W{1'b0}}, sum};  res_scc = add_c[DATA_W]; res_wr = 1'b1; end
          24'h01: begin res_out = {{DATA_W{1'b0}}, diff}; res_scc = lt_u;          res_wr = 1'b1; end
          24'h02: begin res_out = {{DATA_W{1'b0}}, sum};  res_scc = add_ovf;       res_wr = 1'b1; end
          24'h03: begin res_out = {{DATA_W{1'b0}}, diff}; res_scc = sub_ovf;       res_wr = 1'b1; end
          24'h07: begin
            res_out = {{DATA_W{1'b0}}, (lt_u ? a : b)}; res_scc = lt_u; res_wr = 1'b1;
          end
          24'h09: begin
            res_out = {{DATA_W{1'b0}}, (gt_u ? a : b)}; res_scc = gt_u; res_wr = 1'b1;
          end
          24'h0E, 24'h0F: begin res_out = s1 & s2;  res_nz = 1'b1; res_wr = 1'b1; end
          24'h10, 24'h11: begin res_out = s1 | s2;  res_nz = 1'b1; res_wr = 1'b1; end
          24'h12, 24'h13: begin res_out = s1 ^ s2;  res_nz = 1'b1; res_wr = 1'b1; end
          24'h15:         begin res_out = s1 & ~s2; res_nz = 1'b1; res_wr = 1'b1; end
          24'h1E: begin res_out = {{DATA_W{1'b0}}, (a << shamt)}; res_nz = 1'b1; res_wr = 1'b1; end
          24'h20: begin res_out = {{DATA_W{1'b0}}, (a >> shamt)}; res_nz = 1'b1; res_wr = 1'b1; end
          24'h22: begin res_out = {{DATA_W{1'b0}}, ashr_res};     res_nz = 1'b1; res_wr = 1'b1; end
          24'h26: begin res_out = {{DATA_W{1'b0}}, prod[DATA_W-1:0]}; res_mul = 1'b1; end
          default: res_ill = 1'b1;
        endcase
      end
      FMT_SOPC: begin
        case (opc)
          24'h00: begin res_scc = eq;           res_wr = 1'b1; end
          24'h04: begin res_scc = lt_s;         res_wr = 1'b1; end
          24'h05: begin res_scc = lt_s || eq;   res_wr = 1'b1; end
          24'h09: begin res_scc = !lt_u;        res_wr = 1'b1; end
          24'h0A: begin res_scc = lt_u;         res_wr = 1'b1; end
          24'h0B: begin res_scc = lt_u || eq;   res_wr = 1'b1; end
          default: res_ill = 1'b1;
        endcase
      end
      FMT_SOPK: begin
        case (opc)
          24'h00: res_out = s2;
          24'h0F: begin res_out = {{DATA_W{1'b0}}, sum}; res_scc = add_ovf; res_wr = 1'b1; end
          24'h10: begin
            res_out  = {{DATA_W{1'b0}}, prod[DATA_W-1:0]};
            res_scc  = prod_ovf;
            res_wr   = 1'b1;
            res_mul  = 1'b1;
            res_mulk = 1'b1;
          end
          default: res_ill = 1'b1;
        endcase
      end
      default: res_ill = 1'b1;
    endcase
  end

  assign res_out_m = res_out & wmask;
  assign res_scc_f = res_nz ? (|res_out_m) : res_scc;

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Next state, multiply countdown and datapath load strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_res  = 1'b0;
    load_mul  = 1'b0;
    load_prod = 1'b0;
    case (state_q)
      ST_MUL: begin
        if (cnt_q <= 4'd1) begin
          state_d   = ST_HOLD;
          cnt_d     = 4'd0;
          load_prod = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready && !in_valid) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (res_mul && MUL_MULTI) begin
        state_d  = ST_MUL;
        cnt_d    = MUL_LOAD;
        load_mul = 1'b1;
      end else begin
        state_d  = ST_HOLD;
        load_res = 1'b1;
      end
    end
  end

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result and captured-operand next values; unchanged unless a load strobe fires.
  always_comb begin
    out_d     = out_q;
    scc_val_d = scc_val_q;
    scc_wr_d  = scc_wr_q;
    illegal_d = illegal_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_k_d   = mul_k_q;
    if (load_res) begin
      out_d     = res_out_m;
      scc_val_d = res_scc_f;
      scc_wr_d  = res_wr;
      illegal_d = res_ill;
    end
    if (load_mul) begin
      mul_a_d = a;
      mul_b_d = b;
      mul_k_d = res_mulk;
    end
    if (load_prod) begin
      out_d     = {{DATA_W{1'b0}}, prod[DATA_W-1:0]};
      scc_val_d = mul_k_q & prod_ovf;
      scc_wr_d  = mul_k_q;
      illegal_d = 1'b0;
    end
  end

  // Result and multiply operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      scc_val_q <= 1'b0;
      scc_wr_q  <= 1'b0;
      illegal_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_k_q   <= 1'b0;
    end else begin
      out_q     <= out_d;
      scc_val_q <= scc_val_d;
      scc_wr_q  <= scc_wr_d;
      illegal_q <= illegal_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_k_q   <= mul_k_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out       = out_q;
  assign scc_val   = scc_val_q;
  assign scc_wr    = scc_wr_q;
  assign illegal   = illegal_q;

endmodule
